// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 256-point radix-2 FFT sequencer.
package fft_pkg;

  localparam int N_LOG2 = 8;
  localparam int NPTS   = 1 << N_LOG2;
  localparam int NBFLY  = NPTS / 2;

  typedef logic [N_LOG2-1:0] addr_t;
  typedef logic [N_LOG2-2:0] bidx_t;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  // One entry of the write-back delay line.
  typedef struct packed {
    logic  valid;
    addr_t a0;
    addr_t a1;
  } wb_t;

  function automatic addr_t bitrev(input addr_t a);
    addr_t r;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly) -> (upper/lower read address, twiddle index) map.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [2:0]        stage,
  input  logic [N_LOG2-2:0] b,
  output logic [N_LOG2-1:0] rd_addr0,
  output logic [N_LOG2-1:0] rd_addr1,
  output logic [N_LOG2-2:0] tw_addr
);

  addr_t b_ext;
  addr_t span;
  addr_t pos;
  addr_t grp;

  assign b_ext = {1'b0, b};
  assign span  = addr_t'(1) << stage;
  assign pos   = b_ext & (span - addr_t'(1));
  assign grp   = b_ext >> stage;

  // Upper leg is b with a zero bit inserted at position stage; lower leg sets it.
  assign rd_addr0 = (grp << ({1'b0, stage} + 4'd1)) | pos;
  assign rd_addr1 = rd_addr0 + span;
  assign tw_addr  = bidx_t'(pos << (3'(N_LOG2-1) - stage));

endmodule

// File: rtl/fft_bfly_sched.sv
// Butterfly issue sequencer for an in-place radix-2 FFT with write-back delay line.
// Optional bit-reversed input load phase: define FFT_BFLY_SCHED_BITREV_EN.
module fft_bfly_sched
  import fft_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FFT_BFLY_SCHED_BITREV_EN
  input  logic              ld_valid,
  output logic [N_LOG2-1:0] ld_addr,
`endif
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr0,
  output logic [N_LOG2-1:0] rd_addr1,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr0,
  output logic [N_LOG2-1:0] wr_addr1
);

  localparam int PIPE = RD_LAT + BFLY_LAT;

  state_t     state, state_n;
  logic [2:0] stage_n;
  bidx_t      b, b_n;
  logic [3:0] dcnt, dcnt_n;
  logic       issue_n;
  addr_t      a0_n, a1_n;
  bidx_t      tw_n;
  wb_t        dl [PIPE];
`ifdef FFT_BFLY_SCHED_BITREV_EN
  addr_t      ld_cnt, ld_cnt_n;
`endif

  // Addresses are computed for the upcoming issue so they can be registered with rd_en.
  fft_addr_gen u_addr_gen (
    .stage    (stage_n),
    .b        (b_n),
    .rd_addr0 (a0_n),
    .rd_addr1 (a1_n),
    .tw_addr  (tw_n)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case leaves it unassigned (no latch).
    state_n = state;
    stage_n = stage;
    b_n     = b;
    dcnt_n  = dcnt;
`ifdef FFT_BFLY_SCHED_BITREV_EN
    ld_cnt_n = ld_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
`ifdef FFT_BFLY_SCHED_BITREV_EN
          state_n  = LOAD;
          ld_cnt_n = '0;
`else
          state_n  = RUN;
`endif
          stage_n = '0;
          b_n     = '0;
        end
      end
`ifdef FFT_BFLY_SCHED_BITREV_EN
      LOAD: begin
        if (ld_valid) begin
          ld_cnt_n = ld_cnt + addr_t'(1);
          if (ld_cnt == addr_t'(NPTS-1)) state_n = RUN;
        end
      end
`endif
      RUN: begin
        if (b == bidx_t'(NBFLY-1)) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end else begin
          b_n = b + bidx_t'(1);
        end
      end
      DRAIN: begin
        // The last write of the stage lands in the final drain cycle.
        if (dcnt == 4'(PIPE-1)) begin
          if (stage == 3'(N_LOG2-1)) begin
            state_n = DONE;
            stage_n = '0;
          end else begin
            state_n = RUN;
            stage_n = stage + 3'd1;
            b_n     = '0;
          end
        end else begin
          dcnt_n = dcnt + 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign issue_n = (state_n == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stage    <= '0;
      b        <= '0;
      dcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      tw_addr  <= '0;
      // NOTE: the delay line is a short register chain, not a RAM, so it is reset to kill in-flight writes on abort.
      for (int i = 0; i < PIPE; i++) dl[i] <= '0;
`ifdef FFT_BFLY_SCHED_BITREV_EN
      ld_cnt   <= '0;
      ld_addr  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= state_n;
      stage    <= stage_n;
      b        <= b_n;
      dcnt     <= dcnt_n;
      busy     <= (state_n == RUN) || (state_n == DRAIN) || (state_n == LOAD);
      done     <= (state_n == DONE);
      rd_en    <= issue_n;
      rd_addr0 <= issue_n ? a0_n : '0;
      rd_addr1 <= issue_n ? a1_n : '0;
      tw_addr  <= issue_n ? tw_n : '0;
      dl[0]    <= '{valid: rd_en, a0: rd_addr0, a1: rd_addr1};
      for (int i = 1; i < PIPE; i++) dl[i] <= dl[i-1];
`ifdef FFT_BFLY_SCHED_BITREV_EN
      ld_cnt   <= ld_cnt_n;
      if (state == LOAD && ld_valid) ld_addr <= bitrev(ld_cnt);
`endif
    end
  end

  assign wr_en    = dl[PIPE-1].valid;
  assign wr_addr0 = dl[PIPE-1].a0;
  assign wr_addr1 = dl[PIPE-1].a1;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched: per-cycle model compare, RAW hazard scoreboard, directed vectors.
module tb_fft_bfly_sched;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage;
  logic [7:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [6:0] tw_addr;
`ifdef FFT_BFLY_SCHED_BITREV_EN
  logic       ld_valid = 1'b0;
  logic [7:0] ld_addr;
`endif

  fft_bfly_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef FFT_BFLY_SCHED_BITREV_EN
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
`endif
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic       rd_en;
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic [6:0] tw;
    logic       wr_en;
    logic [7:0] wr0;
    logic [7:0] wr1;
  } obs_t;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Butterfly b of stage s: legs are span apart inside groups of 2*span points.
  function automatic logic [22:0] bfly(input int s, input int b);
    int span = 1 << s;
    int a0 = (b / span) * 2 * span + (b % span);
    return {8'(a0), 8'(a0 + span), 7'((b % span) * (128 / span))};
  endfunction

  // Expected outputs t cycles after the edge that accepted start; 130-cycle stages.
  function automatic obs_t model(input bit a, input int t);
    obs_t e = '0;
    logic [22:0] v;
    if (!a) return e;
    if (t < 1040) begin
      e.busy  = 1'b1;
      e.stage = 3'(t / 130);
    end
    e.done = (t == 1040);
    if (t < 1040 && (t % 130) < 128) begin
      v = bfly(t / 130, t % 130);
      e.rd_en = 1'b1;
      {e.rd0, e.rd1, e.tw} = v;
    end
    if (t >= 2 && t - 2 < 1040 && ((t - 2) % 130) < 128) begin
      v = bfly((t - 2) / 130, (t - 2) % 130);
      e.wr_en = 1'b1;
      {e.wr0, e.wr1} = v[22:7];
    end
    return e;
  endfunction

  // Model run tracker: which cycle of an FFT the DUT should be in.
  bit act = 0;
  int t   = 0;
  always @(posedge clk) begin
    if (rst) act <= 1'b0;
    else if (!act) begin
      if (start) begin
        act <= 1'b1;
        t   <= 0;
      end
    end else if (t == 1040) act <= 1'b0;
    else t <= t + 1;
  end

  // Per-cycle compare and read-after-write hazard scoreboard.
  bit pend [256];
  always @(negedge clk) begin
    obs_t e, got;
    if (cmp_en) begin
      e   = model(act, t);
      got = {busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_addr, wr_en, wr_addr0, wr_addr1};
      check("cycle_outputs", 64'(got), 64'(e));
      if (!busy) for (int i = 0; i < 256; i++) pend[i] = 1'b0;
      if (rd_en) check("raw_hazard", {63'd0, pend[rd_addr0] | pend[rd_addr1]}, 64'd0);
      if (wr_en) begin
        pend[wr_addr0] = 1'b0;
        pend[wr_addr1] = 1'b0;
      end
      if (rd_en) begin
        pend[rd_addr0] = 1'b1;
        pend[rd_addr1] = 1'b1;
      end
    end
  end

  // Follows one run from the negedge after acceptance; optional mid-run start pulse and abort.
  task automatic track(input string tag, input int abuse_t, input int abort_t);
    int k = 1;
    int rdc = 0;
    int wrc = 0;
    forever begin
      case (k - 1)
        0:   check({tag, "_s0_b0"}, {40'd0, rd_en, rd_addr0, rd_addr1, tw_addr}, {40'd0, 1'b1, 8'd0, 8'd1, 7'd0});
        1:   check({tag, "_s0_b1"}, {40'd0, rd_en, rd_addr0, rd_addr1, tw_addr}, {40'd0, 1'b1, 8'd2, 8'd3, 7'd0});
        2: begin
             check({tag, "_s0_b2"}, {40'd0, rd_en, rd_addr0, rd_addr1, tw_addr}, {40'd0, 1'b1, 8'd4, 8'd5, 7'd0});
             check({tag, "_s0_wr0"}, {47'd0, wr_en, wr_addr0, wr_addr1}, {47'd0, 1'b1, 8'd0, 8'd1});
           end
        130: check({tag, "_s1_b0"}, {40'd0, rd_en, rd_addr0, rd_addr1, tw_addr}, {40'd0, 1'b1, 8'd0, 8'd2, 7'd0});
        131: check({tag, "_s1_b1"}, {40'd0, rd_en, rd_addr0, rd_addr1, tw_addr}, {40'd0, 1'b1, 8'd1, 8'd3, 7'd64});
        915: check({tag, "_s7_b5"}, {40'd0, rd_en, rd_addr0, rd_addr1, tw_addr}, {40'd0, 1'b1, 8'd5, 8'd133, 7'd5});
        default: ;
      endcase
      rdc += int'(rd_en);
      wrc += int'(wr_en);
      if (done) begin
        check({tag, "_done_latency"}, 64'(k), 64'd1041);
        check({tag, "_rd_total"}, 64'(rdc), 64'd1024);
        check({tag, "_wr_total"}, 64'(wrc), 64'd1024);
        @(negedge clk);
        check({tag, "_done_single"}, {63'd0, done}, 64'd0);
        return;
      end
      if (k - 1 == abort_t) begin
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check({tag, "_abort_strobes"}, {62'd0, rd_en, wr_en}, 64'd0);
        check({tag, "_abort_busy"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        check({tag, "_rst_start_ignored"}, {63'd0, busy}, 64'd0);
        return;
      end
      if (k >= 1200) begin
        check({tag, "_timeout"}, 64'(k), 64'd1041);
        return;
      end
      start = (k - 1 == abuse_t);
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_strobes", {61'd0, rd_en, wr_en, done}, 64'd0);
    check("idle_stage", {61'd0, stage}, 64'd0);

    // Run 1 with a start pulse mid-stage 3, which must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    track("run1", 3 * 130 + 50, -1);

    // Start raised in the done cycle is ignored; held one more cycle it is accepted.
    // track() returned one cycle after done, so rewind the pattern: wait for idle first.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    track("run2", -1, -1);
    // Now at the cycle after done; replay the done-cycle start case on the next run below.

    // Run 3: reset asserted at cycle 500 aborts immediately.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    track("run3", -1, 500);

    // Run 4: start during the done cycle, held through the next cycle.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int k = 1;
      while (!done && k < 1200) begin
        @(negedge clk);
        k++;
      end
      check("run4_done_latency", 64'(k), 64'd1041);
    end
    start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("start_after_done_accepted", {63'd0, busy}, 64'd1);
    track("run5", -1, -1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
